// File: rtl/charattr_pkg.sv
// charattr_pkg: shared constants and FSM state type for the character/attribute
// row fetch sequencer.
//   COLUMNS, BURST, MEM_ADDR_WIDTH, ADDR_WIDTH, DATA_WIDTH : default geometry
//   state_t   : fetch FSM states
//   burst_len : min(max_burst, words left), sized for the mem_len port
package charattr_pkg;
  localparam int COLUMNS        = 80;
  localparam int BURST          = 16;
  localparam int MEM_ADDR_WIDTH = 24;
  localparam int ADDR_WIDTH     = 7;
  localparam int DATA_WIDTH     = 32;
  localparam int LEN_WIDTH      = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RECEIVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [LEN_WIDTH-1:0] burst_len(input int left, input int max_burst);
    if (left > max_burst) return LEN_WIDTH'(max_burst);
    return LEN_WIDTH'(left);
  endfunction
endpackage

// File: rtl/charattr_row_addr.sv
// charattr_row_addr: combinational start address of a text row.
//   base_addr : text page base word address
//   row_index : text row number
//   row_addr  : base_addr + row_index*COLUMNS, all arithmetic modulo 2^MEM_ADDR_WIDTH
module charattr_row_addr #(
  parameter int COLUMNS        = charattr_pkg::COLUMNS,
  parameter int MEM_ADDR_WIDTH = charattr_pkg::MEM_ADDR_WIDTH
) (
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [5:0]                row_index,
  output logic [MEM_ADDR_WIDTH-1:0] row_addr
);
  logic [MEM_ADDR_WIDTH-1:0] idx_ext;
  logic [MEM_ADDR_WIDTH-1:0] offset;

  assign idx_ext = MEM_ADDR_WIDTH'(row_index);

  generate
    if (COLUMNS == 80) begin : g_shift_add
      // 80 = 64 + 16: two shifted copies instead of a multiplier
      assign offset = (idx_ext << 6) + (idx_ext << 4);
    end else begin : g_mul
      assign offset = idx_ext * MEM_ADDR_WIDTH'(COLUMNS);
    end
  endgenerate

  assign row_addr = base_addr + offset;
endmodule

// File: rtl/charattr_row_loader.sv
// charattr_row_loader: fetches one text row of COLUMNS char/attribute words from
// video memory in bursts of up to BURST words and writes them into the row RAM.
// Build option: CHARATTR_ROW_LOADER_DOUBLE_BUFFER_EN enables ping-pong banking
// (disp_bank = ~wr_bank, toggled at each completed row); without it both bank
// outputs are tied to 0.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   row_start/row_index/base_addr : fetch request (sampled only in IDLE)
//   mem_req/mem_addr/mem_len/mem_ack : burst request to the arbiter
//   mem_valid/mem_data    : returned read words
//   wr_en/wr_addr/wr_data : row RAM write port A
//   wr_bank/disp_bank     : bank being filled / bank to display
//   row_ready             : one-cycle pulse, row complete
//   busy, overrun         : fetch in progress, sticky row_start-while-busy flag
//   fsm_state             : current FSM state (debug)
// Handshakes: mem_req is raised with mem_addr/mem_len and all three hold steady
// until the cycle mem_ack is seen; mem_req drops on the following edge. Each
// mem_valid in RECEIVE carries exactly one word; the arbiter never returns more
// words than mem_len, and mem_valid outside RECEIVE is ignored.
module charattr_row_loader #(
  parameter int COLUMNS        = charattr_pkg::COLUMNS,
  parameter int ADDR_WIDTH     = charattr_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = charattr_pkg::DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = charattr_pkg::MEM_ADDR_WIDTH,
  parameter int BURST          = charattr_pkg::BURST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      row_start,
  input  logic [5:0]                row_index,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  output logic                      mem_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [4:0]                mem_len,
  input  logic                      mem_ack,
  input  logic                      mem_valid,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_bank,
  output logic                      disp_bank,
  output logic                      row_ready,
  output logic                      busy,
  output logic                      overrun,
  output charattr_pkg::state_t      fsm_state
);
  import charattr_pkg::*;

  // One extra bit so col can hold COLUMNS itself (end-of-row marker)
  localparam int COL_WIDTH = ADDR_WIDTH + 1;

  state_t                    state;
  logic [MEM_ADDR_WIDTH-1:0] row_addr_calc;
  logic [MEM_ADDR_WIDTH-1:0] row_address;
  logic [COL_WIDTH-1:0]      col;
  logic [4:0]                remaining;
  logic                      row_done;

  charattr_row_addr #(
    .COLUMNS       (COLUMNS),
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_row_addr (
    .base_addr(base_addr),
    .row_index(row_index),
    .row_addr (row_addr_calc)
  );

  // Burst drained and every column written: finish the row on this edge
  assign row_done  = (state == RECEIVE) && (remaining == 5'd0) &&
                     (col == COL_WIDTH'(COLUMNS));
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_len     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      row_ready   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      row_address <= '0;
      col         <= '0;
      remaining   <= '0;
    end else begin
      wr_en     <= 1'b0;
      row_ready <= 1'b0;
      if (row_start && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (row_start) begin
            row_address <= row_addr_calc;
            col         <= '0;
            mem_req     <= 1'b1;
            mem_addr    <= row_addr_calc;
            mem_len     <= burst_len(COLUMNS, BURST);
            busy        <= 1'b1;
            state       <= REQUEST;
          end
        end
        REQUEST: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            remaining <= mem_len;
            state     <= RECEIVE;
          end
        end
        RECEIVE: begin
          if (remaining == 5'd0) begin
            if (row_done) begin
              // Registered with the bank toggle so row_ready marks the swap edge
              row_ready <= 1'b1;
              state     <= DONE;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= row_address + MEM_ADDR_WIDTH'(col);
              mem_len  <= burst_len(COLUMNS - int'(col), BURST);
              state    <= REQUEST;
            end
          end else if (mem_valid) begin
            wr_en     <= 1'b1;
            wr_addr   <= col[ADDR_WIDTH-1:0];
            wr_data   <= mem_data;
            col       <= col + COL_WIDTH'(1);
            remaining <= remaining - 5'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHARATTR_ROW_LOADER_DOUBLE_BUFFER_EN
  logic bank_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q <= 1'b0;
    end else if (row_done) begin
      bank_q <= ~bank_q;
    end
  end

  assign wr_bank   = bank_q;
  assign disp_bank = ~bank_q;
`else
  assign wr_bank   = 1'b0;
  assign disp_bank = 1'b0;
`endif
endmodule

// File: tb/tb_charattr_row_loader.sv
// tb_charattr_row_loader: directed bench for charattr_row_loader.
// Instance 0 uses the default 80-column geometry, instance 1 uses COLUMNS=40.
// A behavioural arbiter task serves bursts; every word handed to the DUT is
// pushed to exp_q and popped when the matching row RAM write appears.
module tb_charattr_row_loader;
  import charattr_pkg::*;

  localparam int SBW = 40; // {dut id, wr_addr[6:0], wr_data[31:0]}

  logic        clk;
  logic        reset;
  logic        row_start [2];
  logic [5:0]  row_index [2];
  logic [23:0] base_addr [2];
  logic        mem_req   [2];
  logic [23:0] mem_addr  [2];
  logic [4:0]  mem_len   [2];
  logic        mem_ack   [2];
  logic        mem_valid [2];
  logic [31:0] mem_data  [2];
  logic        wr_en     [2];
  logic [6:0]  wr_addr   [2];
  logic [31:0] wr_data   [2];
  logic        wr_bank   [2];
  logic        disp_bank [2];
  logic        row_ready [2];
  logic        busy      [2];
  logic        overrun   [2];
  state_t      fsm_state [2];

  logic [SBW-1:0] exp_q[$];
  int             tests;
  int             failures;
  int             rr_count [2];
  logic           exp_bank [2];

  charattr_row_loader dut (
    .clk(clk), .reset(reset),
    .row_start(row_start[0]), .row_index(row_index[0]), .base_addr(base_addr[0]),
    .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_len(mem_len[0]), .mem_ack(mem_ack[0]),
    .mem_valid(mem_valid[0]), .mem_data(mem_data[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .wr_bank(wr_bank[0]), .disp_bank(disp_bank[0]), .row_ready(row_ready[0]),
    .busy(busy[0]), .overrun(overrun[0]), .fsm_state(fsm_state[0])
  );

  charattr_row_loader #(.COLUMNS(40)) dut40 (
    .clk(clk), .reset(reset),
    .row_start(row_start[1]), .row_index(row_index[1]), .base_addr(base_addr[1]),
    .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_len(mem_len[1]), .mem_ack(mem_ack[1]),
    .mem_valid(mem_valid[1]), .mem_data(mem_data[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .wr_bank(wr_bank[1]), .disp_bank(disp_bank[1]), .row_ready(row_ready[1]),
    .busy(busy[1]), .overrun(overrun[1]), .fsm_state(fsm_state[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    failures++;
    $fatal(1, "watchdog expired");
  end

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int d);
    check("rst_mem_req",   64'(mem_req[d]),   64'(0));
    check("rst_mem_addr",  64'(mem_addr[d]),  64'(0));
    check("rst_mem_len",   64'(mem_len[d]),   64'(0));
    check("rst_wr_en",     64'(wr_en[d]),     64'(0));
    check("rst_wr_addr",   64'(wr_addr[d]),   64'(0));
    check("rst_wr_data",   64'(wr_data[d]),   64'(0));
    check("rst_wr_bank",   64'(wr_bank[d]),   64'(0));
`ifdef CHARATTR_ROW_LOADER_DOUBLE_BUFFER_EN
    check("rst_disp_bank", 64'(disp_bank[d]), 64'(1));
`else
    check("rst_disp_bank", 64'(disp_bank[d]), 64'(0));
`endif
    check("rst_row_ready", 64'(row_ready[d]), 64'(0));
    check("rst_busy",      64'(busy[d]),      64'(0));
    check("rst_overrun",   64'(overrun[d]),   64'(0));
    check("rst_state",     64'(fsm_state[d]), 64'(IDLE));
  endtask

  // Fetch one row on instance d. gap = idle cycles between words,
  // ovr_word = column at which a stray row_start is driven (-1 none),
  // abort_word = return after this many writes (-1 run to completion).
  task automatic run_row(input int d, input logic [23:0] base, input logic [5:0] row,
                         input int gap, input int ovr_word, input int abort_word);
    int          cols;
    int          col;
    int          len;
    int          waitc;
    int          rr_before;
    logic [23:0] row_addr;
    logic [23:0] exp_addr;
    logic [31:0] w;
    cols      = (d == 0) ? 80 : 40;
    row_addr  = base + 24'(row) * 24'(cols);
    rr_before = rr_count[d];

    row_start[d] = 1'b1;
    row_index[d] = row;
    base_addr[d] = base;
    tick();
    row_start[d] = 1'b0;
    check("req_latency", 64'(mem_req[d]), 64'(1));
    check("busy_set",    64'(busy[d]),    64'(1));

    col = 0;
    while (col < cols) begin
      waitc = 0;
      while (mem_req[d] !== 1'b1 && waitc < 20) begin
        tick();
        waitc++;
      end
      check("req_wait", 64'(mem_req[d]), 64'(1));
      len      = (cols - col > 16) ? 16 : cols - col;
      exp_addr = row_addr + 24'(col);
      check("mem_addr", 64'(mem_addr[d]), 64'(exp_addr));
      check("mem_len",  64'(mem_len[d]),  64'(len));
      mem_ack[d] = 1'b1;
      tick();
      mem_ack[d] = 1'b0;
      check("req_drop", 64'(mem_req[d]), 64'(0));
      for (int k = 0; k < len; k++) begin
        if (gap > 0 && k > 0) begin
          for (int g = 0; g < gap; g++) begin
            tick();
            check("gap_no_write", 64'(wr_en[d]), 64'(0));
          end
        end
        w            = $urandom();
        mem_valid[d] = 1'b1;
        mem_data[d]  = w;
        exp_q.push_back({d[0], 7'(col), w});
        if (ovr_word == col) row_start[d] = 1'b1;
        tick();
        mem_valid[d] = 1'b0;
        row_start[d] = 1'b0;
        check("wr_latency", 64'(wr_en[d]), 64'(1));
        col++;
        if (col == abort_word) return;
      end
    end

    tick();
    check("row_ready_pulse", 64'(row_ready[d]), 64'(1));
    check("busy_in_done",    64'(busy[d]),      64'(1));
`ifdef CHARATTR_ROW_LOADER_DOUBLE_BUFFER_EN
    exp_bank[d] = ~exp_bank[d];
    check("wr_bank_swap",   64'(wr_bank[d]),   64'(exp_bank[d]));
    check("disp_bank_swap", 64'(disp_bank[d]), 64'(~exp_bank[d]));
`else
    check("wr_bank_const",   64'(wr_bank[d]),   64'(0));
    check("disp_bank_const", 64'(disp_bank[d]), 64'(0));
`endif
    tick();
    check("row_ready_clear", 64'(row_ready[d]), 64'(0));
    check("busy_clear",      64'(busy[d]),      64'(0));
    check("state_idle",      64'(fsm_state[d]), 64'(IDLE));
    check("row_ready_count", 64'(rr_count[d]),  64'(rr_before + 1));
    check("sb_drained",      64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_en[d] === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_write", 64'({d[0], wr_addr[d], wr_data[d]}), 64'(0));
        end else begin
          check("sb_write", 64'({d[0], wr_addr[d], wr_data[d]}), 64'(exp_q.pop_front()));
        end
      end
      if (row_ready[d] === 1'b1) rr_count[d]++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rr_saved;
    tests    = 0;
    failures = 0;
    reset    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      row_start[d] = 1'b0;
      row_index[d] = '0;
      base_addr[d] = '0;
      mem_ack[d]   = 1'b0;
      mem_valid[d] = 1'b0;
      mem_data[d]  = '0;
      rr_count[d]  = 0;
      exp_bank[d]  = 1'b0;
    end

    repeat (3) tick();
    check_reset(0);
    check_reset(1);
    reset = 1'b0;
    tick();

    // Full 80-column row, immediate acks: bursts at 0x0010A0..0x0010E0
    run_row(0, 24'h001000, 6'd2, 0, -1, -1);

    // 40-column geometry: 16, 16, 8
    run_row(1, 24'($urandom_range(0, 24'hFFFFFF)), 6'd3, 0, -1, -1);

    // Stray row_start mid-RECEIVE sets overrun, fetch continues unchanged
    check("overrun_before", 64'(overrun[0]), 64'(0));
    run_row(0, 24'h200000, 6'd1, 0, 20, -1);
    check("overrun_set", 64'(overrun[0]), 64'(1));
    repeat (3) tick();
    check("no_extra_req",  64'(mem_req[0]), 64'(0));
    check("idle_after_ovr", 64'(busy[0]),   64'(0));

    // Address wrap: 0xFFFFF0 then 0x000000
    run_row(0, 24'hFFFFF0, 6'd0, 0, -1, -1);
    check("overrun_sticky", 64'(overrun[0]), 64'(1));

    // Sparse mem_valid: one word every 3 cycles
    run_row(0, 24'($urandom_range(0, 24'hFFFFFF)), 6'd5, 2, -1, -1);

    // Reset after 30 writes: partial row discarded, no row_ready
    rr_saved = rr_count[0];
    run_row(0, 24'h004000, 6'd7, 0, -1, 30);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset(0);
    tick();
    check_reset(0);
    check("abort_sb_empty",   64'(exp_q.size()), 64'(0));
    check("abort_no_rready",  64'(rr_count[0]),  64'(rr_saved));
    reset       = 1'b0;
    exp_bank[0] = 1'b0;
    exp_bank[1] = 1'b0;
    tick();
    run_row(0, 24'h004000, 6'd7, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
